// File: rtl/io_dispatcher.sv
// IO request sequencer: decodes a request into one of NUM_DEV device windows, runs the
// select/finish handshake on the shared device bus and returns data or an exception code.
module io_dispatcher #(
  parameter int NUM_DEV        = 4,
  parameter int DEV_ADDR_BITS  = 12,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int EXCEPTION_LEN  = 4,
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_OK                = EXCEPTION_LEN'(0),
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = EXCEPTION_LEN'(5),
  parameter logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = EXCEPTION_LEN'(7)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [31:0]                      io_addr_In,
  input  logic [31:0]                      io_data_In,
  input  logic [1:0]                       io_dataWidth_In,
  input  logic                             io_isRead_In,
  input  logic                             io_select_In,
  output logic                             io_finish_Out,
  output logic [31:0]                      io_data_Out,
  output logic [EXCEPTION_LEN-1:0]         io_exception_Out,
  output logic [DEV_ADDR_BITS-1:0]         dev_addr_Out,
  output logic [31:0]                      dev_data_Out,
  output logic [1:0]                       dev_dataWidth_Out,
  output logic                             dev_isRead_Out,
  output logic [NUM_DEV-1:0]               dev_select_Out,
  input  logic [NUM_DEV-1:0]               dev_finish_In,
  input  logic [32*NUM_DEV-1:0]            dev_data_In,
  input  logic [EXCEPTION_LEN*NUM_DEV-1:0] dev_exception_In
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int WIN_W = 30 - DEV_ADDR_BITS;

  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERROR} state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [IDX_W-1:0]         req_idx_reg;
  logic [DEV_ADDR_BITS-1:0] req_addr_reg;
  logic [31:0]              req_data_reg;
  logic [1:0]               req_width_reg;
  logic                     req_isread_reg;

  logic [31:0]              dev_data_arr [NUM_DEV];
  logic [EXCEPTION_LEN-1:0] dev_exc_arr  [NUM_DEV];

  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_unpack
      assign dev_data_arr[gi] = dev_data_In[32*gi +: 32];
      assign dev_exc_arr[gi]  = dev_exception_In[EXCEPTION_LEN*gi +: EXCEPTION_LEN];
    end
  endgenerate

  // Address bits [31:30] are always zero inside the IO region.
  logic unused_addr_bits;
  assign unused_addr_bits = ^io_addr_In[31:30];

  logic [WIN_W-1:0] win_in;
  logic [IDX_W-1:0] idx_in;
  logic             decode_err;
  logic             fin_sel;

  assign win_in  = io_addr_In[29:DEV_ADDR_BITS];
  assign idx_in  = win_in[IDX_W-1:0];
  assign fin_sel = dev_finish_In[req_idx_reg];

  always_comb begin
    decode_err = (win_in >= WIN_W'(NUM_DEV))
              || (io_dataWidth_In == MEM_WIDTH_HALF && io_addr_In[0])
              || (io_dataWidth_In == MEM_WIDTH_WORD && io_addr_In[1:0] != 2'b00);
  end

  // Request currently being served: live inputs on the accepting edge, latched copy afterwards.
  logic [IDX_W-1:0]         cur_idx;
  logic [DEV_ADDR_BITS-1:0] cur_addr;
  logic [31:0]              cur_data;
  logic [1:0]               cur_width;
  logic                     cur_isread;

  always_comb begin
    if (state_reg == IDLE) begin
      cur_idx    = idx_in;
      cur_addr   = io_addr_In[DEV_ADDR_BITS-1:0];
      cur_data   = io_data_In;
      cur_width  = io_dataWidth_In;
      cur_isread = io_isRead_In;
    end else begin
      cur_idx    = req_idx_reg;
      cur_addr   = req_addr_reg;
      cur_data   = req_data_reg;
      cur_width  = req_width_reg;
      cur_isread = req_isread_reg;
    end
  end

  logic                     io_finish_next;
  logic [31:0]              io_data_next;
  logic [EXCEPTION_LEN-1:0] io_exc_next;
  logic [DEV_ADDR_BITS-1:0] dev_addr_next;
  logic [31:0]              dev_data_next;
  logic [1:0]               dev_width_next;
  logic                     dev_isread_next;
  logic [NUM_DEV-1:0]       dev_select_next;

  // State register, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      req_idx_reg       <= '0;
      req_addr_reg      <= '0;
      req_data_reg      <= '0;
      req_width_reg     <= '0;
      req_isread_reg    <= 1'b0;
      io_finish_Out     <= 1'b0;
      io_data_Out       <= '0;
      io_exception_Out  <= '0;
      dev_addr_Out      <= '0;
      dev_data_Out      <= '0;
      dev_dataWidth_Out <= '0;
      dev_isRead_Out    <= 1'b0;
      dev_select_Out    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && io_select_In) begin
        req_idx_reg    <= idx_in;
        req_addr_reg   <= io_addr_In[DEV_ADDR_BITS-1:0];
        req_data_reg   <= io_data_In;
        req_width_reg  <= io_dataWidth_In;
        req_isread_reg <= io_isRead_In;
      end
      io_finish_Out     <= io_finish_next;
      io_data_Out       <= io_data_next;
      io_exception_Out  <= io_exc_next;
      dev_addr_Out      <= dev_addr_next;
      dev_data_Out      <= dev_data_next;
      dev_dataWidth_Out <= dev_width_next;
      dev_isRead_Out    <= dev_isread_next;
      dev_select_Out    <= dev_select_next;
    end
  end

  // Next state; a dropped select has priority over device finish and timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (io_select_In) begin
          state_next = decode_err ? ERROR : ISSUE;
          cnt_next   = '0;
        end
      end
      ISSUE: begin
        if (!io_select_In)
          state_next = IDLE;
        else if (fin_sel)
          state_next = DONE;
        else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1))
          state_next = ERROR;
        else
          cnt_next = cnt_reg + 1'b1;
      end
      DONE, ERROR: begin
        if (!io_select_In)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the state being entered.
  always_comb begin
    io_finish_next  = 1'b0;
    io_data_next    = '0;
    io_exc_next     = EXCEP_OK;
    dev_addr_next   = '0;
    dev_data_next   = '0;
    dev_width_next  = '0;
    dev_isread_next = 1'b0;
    dev_select_next = '0;
    case (state_next)
      ISSUE: begin
        dev_select_next = NUM_DEV'(1) << cur_idx;
        dev_addr_next   = cur_addr;
        dev_data_next   = cur_data;
        dev_width_next  = cur_width;
        dev_isread_next = cur_isread;
      end
      DONE: begin
        io_finish_next = 1'b1;
        if (state_reg == ISSUE) begin
          io_data_next = req_isread_reg ? dev_data_arr[req_idx_reg] : 32'd0;
          io_exc_next  = dev_exc_arr[req_idx_reg];
        end else begin
          io_data_next = io_data_Out;
          io_exc_next  = io_exception_Out;
        end
      end
      ERROR: begin
        io_finish_next = 1'b1;
        io_exc_next    = cur_isread ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_io_dispatcher.sv
// Randomized scoreboard bench for io_dispatcher: a request-level model predicts each
// response and its finish edge; a monitor compares every finish against the queue.
module tb_io_dispatcher;
  localparam int NUM_DEV = 4;
  localparam int DAB     = 12;
  localparam int TO      = 256;
  localparam int EL      = 4;
  localparam logic [EL-1:0] X_OK = 4'd0;
  localparam logic [EL-1:0] X_RD = 4'd5;
  localparam logic [EL-1:0] X_WR = 4'd7;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] io_addr_In, io_data_In;
  logic [1:0]  io_dataWidth_In;
  logic        io_isRead_In, io_select_In;
  logic        io_finish_Out;
  logic [31:0] io_data_Out;
  logic [EL-1:0] io_exception_Out;
  logic [DAB-1:0] dev_addr_Out;
  logic [31:0] dev_data_Out;
  logic [1:0]  dev_dataWidth_Out;
  logic        dev_isRead_Out;
  logic [NUM_DEV-1:0] dev_select_Out;
  logic [NUM_DEV-1:0] dev_finish_In;
  logic [32*NUM_DEV-1:0] dev_data_In;
  logic [EL*NUM_DEV-1:0] dev_exception_In;

  io_dispatcher #(
    .NUM_DEV(NUM_DEV), .DEV_ADDR_BITS(DAB), .TIMEOUT_CYCLES(TO), .EXCEPTION_LEN(EL),
    .EXCEP_OK(X_OK), .EXCEP_INVALID_MEM_READ(X_RD), .EXCEP_INVALID_MEM_WRITE(X_WR)
  ) dut (
    .clk(clk), .rst(rst),
    .io_addr_In(io_addr_In), .io_data_In(io_data_In), .io_dataWidth_In(io_dataWidth_In),
    .io_isRead_In(io_isRead_In), .io_select_In(io_select_In),
    .io_finish_Out(io_finish_Out), .io_data_Out(io_data_Out), .io_exception_Out(io_exception_Out),
    .dev_addr_Out(dev_addr_Out), .dev_data_Out(dev_data_Out), .dev_dataWidth_Out(dev_dataWidth_Out),
    .dev_isRead_Out(dev_isRead_Out), .dev_select_Out(dev_select_Out),
    .dev_finish_In(dev_finish_In), .dev_data_In(dev_data_In), .dev_exception_In(dev_exception_In)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int txn = 0;

  typedef struct {
    logic [31:0]   data;
    logic [EL-1:0] exc;
  } resp_t;
  resp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising io_finish_Out consumes one predicted response.
  logic  fin_prev = 1'b0;
  resp_t mon_r;
  always @(negedge clk) begin
    if (rst !== 1'b1 && io_finish_Out === 1'b1 && fin_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_finish: io_finish_Out=1 with no access outstanding at %0t", $time);
      end else begin
        mon_r = exp_q.pop_front();
        check("io_data", {32'd0, io_data_Out}, {32'd0, mon_r.data});
        check("io_exception", {60'd0, io_exception_Out}, {60'd0, mon_r.exc});
        txn++;
        $display("txn %0d: finish data=0x%08h exc=%0d (expected 0x%08h/%0d)",
                 txn, io_data_Out, io_exception_Out, mon_r.data, mon_r.exc);
      end
    end
    fin_prev <= io_finish_Out;
  end

  // One access. lat: edge (counted from the select-sampling edge 0) at which the selected
  // device first raises finish; abort_at: edge at which the requester drops select (-1 none).
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] width,
                        input logic rd, input int lat, input logic [31:0] ddata,
                        input logic [EL-1:0] dexc, input int abort_at, input int hold);
    int idx, end_edge, kend;
    bit err, aborted;
    resp_t r;
    logic [NUM_DEV-1:0] oh;
    idx = int'(addr[29:DAB]);
    err = (idx >= NUM_DEV) || (width == W_HALF && addr[0]) || (width == W_WORD && addr[1:0] != 2'b00);
    oh  = err ? '0 : (NUM_DEV'(1) << idx);
    if (err) begin
      end_edge = 0;
      r.data = 32'd0;
      r.exc  = rd ? X_RD : X_WR;
    end else if (lat >= 1 && lat <= TO) begin
      end_edge = lat;
      r.data = rd ? ddata : 32'd0;
      r.exc  = dexc;
    end else begin
      end_edge = TO;
      r.data = 32'd0;
      r.exc  = rd ? X_RD : X_WR;
    end
    aborted = !err && abort_at >= 1 && abort_at <= end_edge;
    kend = aborted ? abort_at : end_edge;
    if (!aborted) exp_q.push_back(r);

    @(posedge clk); #1;
    io_addr_In = addr; io_data_In = wdata; io_dataWidth_In = width;
    io_isRead_In = rd; io_select_In = 1'b1; dev_finish_In = '0;
    @(posedge clk); #1;  // edge 0
    for (int k = 1; k <= kend; k++) begin
      dev_finish_In = NUM_DEV'($urandom) & ~oh;
      if (k == lat) dev_finish_In = dev_finish_In | oh;
      dev_data_In = {$urandom, $urandom, $urandom, $urandom};
      dev_exception_In = (EL*NUM_DEV)'($urandom);
      if (!err) begin
        dev_data_In[32*idx +: 32] = ddata;
        dev_exception_In[EL*idx +: EL] = dexc;
      end
      io_addr_In = $urandom; io_data_In = $urandom;
      io_dataWidth_In = 2'($urandom); io_isRead_In = 1'($urandom);
      if (k == abort_at) io_select_In = 1'b0;
      @(negedge clk);
      check("dev_select_issue", {60'd0, dev_select_Out}, {60'd0, oh});
      check("no_early_finish", {63'd0, io_finish_Out}, 64'd0);
      check("dev_addr", {52'd0, dev_addr_Out}, {52'd0, addr[DAB-1:0]});
      check("dev_data", {32'd0, dev_data_Out}, {32'd0, wdata});
      check("dev_width", {62'd0, dev_dataWidth_Out}, {62'd0, width});
      check("dev_isread", {63'd0, dev_isRead_Out}, {63'd0, rd});
      @(posedge clk); #1;
    end
    dev_finish_In = NUM_DEV'($urandom) | oh;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check("abort_dev_select", {60'd0, dev_select_Out}, 64'd0);
        check("abort_no_finish", {63'd0, io_finish_Out}, 64'd0);
      end
      dev_finish_In = '0;
      $display("txn abort: addr=0x%08h dropped at edge %0d", addr, abort_at);
      return;
    end
    @(negedge clk);
    check("finish_latency", {63'd0, io_finish_Out}, 64'd1);
    check("dev_select_after", {60'd0, dev_select_Out}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_finish", {63'd0, io_finish_Out}, 64'd1);
      check("hold_data", {32'd0, io_data_Out}, {32'd0, r.data});
      check("hold_exc", {60'd0, io_exception_Out}, {60'd0, r.exc});
    end
    io_select_In = 1'b0;
    dev_finish_In = '0;
    @(negedge clk);
    check("drop_finish", {63'd0, io_finish_Out}, 64'd0);
    check("drop_data", {32'd0, io_data_Out}, 64'd0);
    check("drop_exc", {60'd0, io_exception_Out}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ridx, rlat, rabort, rhold;
  logic [1:0] rwidth;
  logic [31:0] raddr;

  initial begin
    rst = 1'b1;
    io_addr_In = '0; io_data_In = '0; io_dataWidth_In = '0; io_isRead_In = 1'b0; io_select_In = 1'b0;
    dev_finish_In = '0; dev_data_In = '0; dev_exception_In = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_finish", {63'd0, io_finish_Out}, 64'd0);
    check("rst_data", {32'd0, io_data_Out}, 64'd0);
    check("rst_exc", {60'd0, io_exception_Out}, 64'd0);
    check("rst_dev_select", {60'd0, dev_select_Out}, 64'd0);
    check("rst_dev_addr", {52'd0, dev_addr_Out}, 64'd0);
    check("rst_dev_data", {32'd0, dev_data_Out}, 64'd0);
    check("rst_dev_width", {62'd0, dev_dataWidth_Out}, 64'd0);
    check("rst_dev_isread", {63'd0, dev_isRead_Out}, 64'd0);

    // Directed cases
    access(32'h0000_1004, 32'h1234_5678, W_WORD, 1'b1, 3, 32'hDEAD_BEEF, X_OK, -1, 1);
    access(32'h0000_3010, 32'h0000_ABCD, W_HALF, 1'b0, 1, 32'hFFFF_FFFF, X_OK, -1, 0);
    access(32'h0000_4000, 32'h0, W_WORD, 1'b1, 1, 32'h0, X_OK, -1, 1);
    access(32'h0000_1002, 32'h5555_AAAA, W_WORD, 1'b0, 1, 32'h0, X_OK, -1, 0);
    access(32'h0000_0003, 32'h0, W_HALF, 1'b1, 1, 32'h0, X_OK, -1, 0);
    access(32'h0000_0003, 32'h0, W_BYTE, 1'b1, 2, 32'h0000_00A5, X_OK, -1, 0);
    access(32'h0000_2100, 32'h0, W_WORD, 1'b1, 257, 32'h0BAD_0BAD, X_OK, -1, 1);
    access(32'h0000_2104, 32'h0, W_WORD, 1'b1, 256, 32'hC0FF_EE00, X_OK, -1, 0);
    access(32'h0000_2008, 32'h0, W_WORD, 1'b0, 0, 32'h0, X_OK, -1, 0);
    access(32'h0000_0008, 32'h0, W_WORD, 1'b1, 10, 32'h0, X_OK, 5, 0);
    access(32'h0000_0ff0, 32'h0, W_WORD, 1'b1, 2, 32'h1111_2222, 4'd3, -1, 2);

    // Reset in the middle of ISSUE
    @(posedge clk); #1;
    io_addr_In = 32'h0000_2040; io_isRead_In = 1'b1; io_dataWidth_In = W_WORD; io_select_In = 1'b1;
    dev_finish_In = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_mid_pre_select", {60'd0, dev_select_Out}, 64'd4);
    rst = 1'b1; io_select_In = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_select", {60'd0, dev_select_Out}, 64'd0);
    check("rst_mid_finish", {63'd0, io_finish_Out}, 64'd0);
    check("rst_mid_dev_addr", {52'd0, dev_addr_Out}, 64'd0);
    check("rst_mid_dev_isread", {63'd0, dev_isRead_Out}, 64'd0);
    $display("txn reset: mid-ISSUE reset applied");
    access(32'h0000_2040, 32'h0, W_WORD, 1'b1, 2, 32'h7777_0001, X_OK, -1, 0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      ridx   = $urandom_range(0, 4);
      raddr  = (32'(ridx) << DAB) | 32'($urandom_range(0, 4095));
      rwidth = 2'($urandom_range(0, 2));
      rlat   = $urandom_range(1, 8);
      rabort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rlat) : -1;
      rhold  = $urandom_range(0, 2);
      access(raddr, $urandom, rwidth, 1'($urandom), rlat, $urandom, EL'($urandom), rabort, rhold);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/io_dispatcher.md
Name: io_dispatcher

Overview:
Sequencer behind the memory subsystem's IO interface (IO region [3GiB,4GiB), presented with address bits [31:30] zeroed). Decodes each IO request into one of NUM_DEV fixed-size device windows and drives a shared device bus with a one-hot select. Runs a select/finish handshake per access, enforces alignment, bounds device latency with a timeout and returns read data or an exception code upstream.

Parameters:
NUM_DEV, 4, number of device slots; slot i owns bytes [i*2^DEV_ADDR_BITS, (i+1)*2^DEV_ADDR_BITS) of the IO region.
DEV_ADDR_BITS, 12, log2 of window size in bytes (4 KiB windows).
TIMEOUT_CYCLES, 256, cycles in ISSUE without dev_finish before the access is failed; must be >=2.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
io_addr_In  in  32  byte address within IO region.
io_data_In  in  32  write data, right-aligned.
io_dataWidth_In  in  2  MEM_WIDTH_BYTE/HALF/WORD encoding.
io_isRead_In  in  1  1=read, 0=write.
io_select_In  in  1  request valid; held high until finish observed.
io_finish_Out  out  1  access complete (data/exception valid).
io_data_Out  out  32  read data.
io_exception_Out  out  EXCEPTION_LEN  EXCEP_OK or error code.
dev_addr_Out  out  DEV_ADDR_BITS  offset within selected window.
dev_data_Out  out  32  write data to device.
dev_dataWidth_Out  out  2  width to device.
dev_isRead_Out  out  1  direction to device.
dev_select_Out  out  NUM_DEV  one-hot device select.
dev_finish_In  in  NUM_DEV  per-device completion.
dev_data_In  in  32*NUM_DEV  per-device read data, slot i at [32i+31:32i].
dev_exception_In  in  EXCEPTION_LEN*NUM_DEV  per-device exception, slot i at slice i.

Behaviour:
- All outputs registered. Reset: state IDLE, every output 0, timeout counter 0, latched request cleared. Reset in any state aborts the access immediately; dev_select_Out is 0 after the reset edge.
- States: IDLE, ISSUE, DONE, ERROR.
- IDLE: on edge with io_select_In=1, latch addr/data/width/isRead. idx = io_addr_In[29:DEV_ADDR_BITS]. Error if idx>=NUM_DEV, or HALF with addr[0]=1, or WORD with addr[1:0]!=0. On error go to ERROR (no dev_select asserted), else go to ISSUE with counter=0.
- ISSUE: dev_select_Out has only bit idx set; dev_* bus driven from latched values, stable for the whole state; request-side input changes are ignored. Per edge:
  - io_select_In=0: abort to IDLE; dev_select_Out=0 next cycle; no finish pulse.
  - else dev_finish_In[idx]=1: capture dev_data_In slice idx (reads only, 0 for writes) and dev_exception_In slice idx; go to DONE; dev_select_Out cleared.
  - else if counter==TIMEOUT_CYCLES-1: go to ERROR; else counter+1.
  - Finish bits of unselected devices are ignored.
- DONE: io_finish_Out=1, io_data_Out/io_exception_Out = captured values, held while io_select_In=1. The edge sampling io_select_In=0 returns to IDLE and clears io_finish_Out, io_data_Out and io_exception_Out to 0.
- ERROR: io_finish_Out=1, io_data_Out=0, io_exception_Out = EXCEP_INVALID_MEM_READ if latched isRead else EXCEP_INVALID_MEM_WRITE. Same exit rule as DONE.
- Latency: select sampled at edge 0 puts dev_select high after edge 0. dev_finish sampled at edge k puts io_finish_Out high after edge k. Minimum 2 cycles select to finish. Decode/alignment error: finish after edge 0 (1 cycle).
- Back-to-back: requester must drop io_select_In for at least one edge between accesses. Every access passes through IDLE.
- Counter width clog2(TIMEOUT_CYCLES); no wrap possible.

Test Plan:
- Read: addr 0x0000_1004, WORD, dev1 asserts finish 3 cycles after its select with data 0xDEADBEEF -> dev_select=4'b0010, dev_addr=0x004, io_finish after that edge, io_data=0xDEADBEEF, exception EXCEP_OK. Drop select -> outputs 0 next cycle.
- Write: addr 0x0000_3010, HALF, data 0x0000_ABCD, dev3 finishes in 1 cycle -> dev_select=4'b1000, dev_data=0x0000_ABCD, dev_isRead=0, io_finish after 2 cycles total, io_data=0.
- Unmapped/misaligned: read addr 0x0000_4000 (NUM_DEV=4) -> finish 1 cycle later, INVALID_MEM_READ, dev_select never set. WORD write addr 0x0000_1002 -> INVALID_MEM_WRITE.
- Timeout: read dev2, dev_finish held 0 -> after 256 cycles in ISSUE, ERROR with INVALID_MEM_READ and dev_select=0. dev2 finishing at cycle 257 is ignored.
- Abort/reset: drop io_select_In at cycle 5 of ISSUE -> dev_select=0 next cycle, no io_finish. Repeat with rst pulse mid-ISSUE -> all outputs 0 next cycle, state IDLE.
- Device exception passthrough: dev0 finishes with non-OK exception code -> io_exception_Out equals that code while in DONE.
